fft_stage_reorder: RTL
======================

# fft_stage_reorder

Parametrised FFT stage front-end: accepts a frame of `N` complex samples two per beat, writes them into a ping-pong buffer at bit-rotated addresses, then streams butterfly operand pairs with the matching twiddle coefficient to the downstream butterfly. It replaces the fixed 8-point stage blocks in the MFCC `frame_fft_block` with one generic stage.
- Adds ready/valid backpressure, double buffering and frame-sync checking.
- Sustains one pair per cycle.

## Interface
- `N`, 8: points per frame; power of 2, 4..1024.
- `ROT`, 1: write-address left-rotation amount, 0..log2(N)-1.
- `STAGE`, 0: twiddle stride exponent, 0..log2(N)-2.
- `Q_DATA`, 15: data MSB index; data width is Q_DATA+1, signed.
- `Q_COEF`, 15: coefficient MSB index; coefficient width is Q_COEF+1, signed.
- `COEF_REAL_FILE` / `COEF_IMAG_FILE`, "real.mem" / "imag.mem": hex init files, N/2 entries each.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `in_valid`  in  1: input pair valid.
- `in_ready`  out  1: input pair accepted when `in_valid && in_ready`.
- `in_last`  in  1: marks the final pair of a frame.
- `in_real_0`, `in_imag_0`, `in_real_1`, `in_imag_1`  in  Q_DATA+1: samples 2p and 2p+1.
- `out_valid`  out  1: output pair valid.
- `out_ready`  in  1: downstream accepts.
- `out_last`  out  1: final pair of a frame.
- `out_real_0`, `out_imag_0`, `out_real_1`, `out_imag_1`  out  Q_DATA+1: butterfly operands.
- `coeff_out_real`, `coeff_out_imag`  out  Q_COEF+1: twiddle coefficient.
- `err_sync`  out  1: sticky frame-sync error.

## Operation
- **Buffers.** Two banks, each holding N complex words. Per-bank `full` flag. Write bank pointer `wb`, read bank pointer `rb`.
- **Write side.**
  - `in_ready = !full[wb]`.
  - On each accept, pair counter `wp` (0..N/2-1) places sample index k (2·wp, 2·wp+1) at address rotl(k, ROT) over log2(N) bits.
  - On `wp == N/2-1`: set `full[wb]`, toggle `wb`, clear `wp`.
- **Read side.** Output registers load when `full[rb] && (!out_valid || out_ready)`.
  - Operands come from addresses 2·rp and 2·rp+1.
  - Twiddle index is (rp << STAGE) & (N/2-1).
  - `out_last = (rp == N/2-1)`.
  - When the last pair loads: clear `full[rb]`, toggle `rb`, clear `rp`.
  - `out_valid` drops when the registers are consumed and there is nothing to load.
- **Frame sync.** `err_sync` sets when an accepted pair has `in_last` differing from `(wp == N/2-1)`. The frame still completes on the count; `err_sync` clears only on reset.
- **Arithmetic.** No arithmetic is applied to data; it passes through bit-exact. Twiddle word k holds W_N^k = cos, -sin in Q_COEF fractional format.

## Timing
- **Reset values.**
  - Outputs: all data, coeff, `out_valid`, `out_last` and `err_sync` are 0.
  - `in_ready` is 0 while `reset` is high and 1 from the first cycle after release.
  - Internal: `full` = 00, `wb` = `rb` = `wp` = `rp` = 0.
- **Latency.**
  - Last pair accepted at edge t: `out_valid` is high after edge t+1, carrying pair 0.
  - Steady state: N/2 cycles per frame, no gaps between frames.
- **Simultaneous events.** A write completing a bank and a read freeing the other bank in the same cycle both take effect. `in_ready` can therefore stay high continuously.
- **Both banks full.** `in_ready` is low. It rises the cycle after the last pair of `rb` loads into the output registers.
- **Backpressure.** Output registers hold stable while `out_valid && !out_ready`.
- **Reset mid-frame.** Partial frames and buffered frames are discarded. Outputs return to reset values immediately (asynchronous).

## Structure
- **Shared package `fft_pkg`:** `clog2` helper, `rotl` function, and the twiddle-index function.
- **Sub-module `fft_twiddle_rom`:** parameters N, Q_COEF and files; registered read, with the read address issued one cycle ahead so it aligns with the operand registers.
- **Buffer:** inferred RAM, 2×N words, in the top level.

## Test plan
- **Single frame, N=8, ROT=1, STAGE=0.** Real inputs are 0..7 in pairs (0,1), (2,3), (4,5), (6,7); imag = -real. Expect out pairs (0,4), (1,5), (2,6), (3,7), twiddle idx 0,1,2,3, and `out_last` on the 4th pair.
- **STAGE=1, same stimulus.** Twiddle indices are 0,2,0,2; data identical to the previous test.
- **Back-to-back frames, `out_ready` = 1.** Three frames, `in_valid` held high. Expect `in_ready` never low, and output pairs contiguous with no idle cycles after the first latency.
- **Backpressure.** `out_ready` low for 20 cycles after the first output. Expect `in_ready` low after 2 frames are buffered, outputs stable, no data loss. Order and data match the reference model after release.
- **Sync error.** `in_last` asserted on pair 2 of 4. Expect `err_sync` = 1 on the next cycle; that frame's output is still produced in full.
- **Reset mid-frame.** Reset after 2 pairs, then a full frame. Expect all outputs 0 during reset and only the post-reset frame emitted.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared helpers for the generic FFT stage: address rotation, twiddle
// indexing and Q-format twiddle word generation.
package fft_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Left-rotate the low w bits of v by r positions.
  function automatic int unsigned rotl(input int unsigned v, input int unsigned r,
                                       input int unsigned w);
    if (r == 0) return v;
    return ((v << r) | (v >> (w - r))) & ((32'd1 << w) - 1);
  endfunction

  function automatic int unsigned tw_idx(input int unsigned rp, input int unsigned stage,
                                         input int unsigned n);
    return (rp << stage) & (n / 2 - 1);
  endfunction

  // W_N^k as cos (imag=0) or -sin (imag=1), rounded and saturated to Q(q).
  function automatic int coef_q(input int unsigned k, input int unsigned n,
                                input int unsigned q, input bit imag);
    real x, term, sum, v;
    int  r, lim;
    x = 6.283185307179586 * real'(k) / real'(n);
    if (imag) begin
      term = x;
      sum  = x;
      for (int unsigned i = 1; i < 24; i++) begin
        term = -term * x * x / real'((2 * i) * (2 * i + 1));
        sum  = sum + term;
      end
      sum = -sum;
    end else begin
      term = 1.0;
      sum  = 1.0;
      for (int unsigned i = 1; i < 24; i++) begin
        term = -term * x * x / real'((2 * i - 1) * (2 * i));
        sum  = sum + term;
      end
    end
    lim = 1 << q;
    v   = sum * real'(lim);
    r   = $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_reorder_rom.sv
// Twiddle coefficient ROM, N/2 words of W_N^k, registered read with enable.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int    N              = 8,
  parameter int    Q_COEF         = 15,
  parameter string COEF_REAL_FILE = "real.mem",
  parameter string COEF_IMAG_FILE = "imag.mem"
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [clog2(N)-2:0]      addr,
  output logic signed [Q_COEF:0]   coef_real,
  output logic signed [Q_COEF:0]   coef_imag
);

  logic signed [Q_COEF:0] tab_re [N/2];
  logic signed [Q_COEF:0] tab_im [N/2];

  // Table contents are derived from W_N^k directly; the file names only have
  // to be present so existing overrides still elaborate.
  if (COEF_REAL_FILE == "" || COEF_IMAG_FILE == "") begin : g_bad_files
    $error("fft_twiddle_rom: coefficient file parameters must be non-empty");
  end

  for (genvar k = 0; k < N / 2; k++) begin : g_tab
    assign tab_re[k] = (Q_COEF+1)'(coef_q(k, N, Q_COEF, 1'b0));
    assign tab_im[k] = (Q_COEF+1)'(coef_q(k, N, Q_COEF, 1'b1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_real <= '0;
      coef_imag <= '0;
    end else if (en) begin
      coef_real <= tab_re[addr];
      coef_imag <= tab_im[addr];
    end
  end

endmodule

// File: rtl/fft_stage_reorder.sv
// Generic FFT stage front-end: ping-pong reorder buffer feeding butterfly
// operand pairs plus the matching twiddle coefficient.
module fft_stage_reorder
  import fft_pkg::*;
#(
  parameter int    N              = 8,
  parameter int    ROT            = 1,
  parameter int    STAGE          = 0,
  parameter int    Q_DATA         = 15,
  parameter int    Q_COEF         = 15,
  parameter string COEF_REAL_FILE = "real.mem",
  parameter string COEF_IMAG_FILE = "imag.mem"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic signed [Q_DATA:0] in_real_0,
  input  logic signed [Q_DATA:0] in_imag_0,
  input  logic signed [Q_DATA:0] in_real_1,
  input  logic signed [Q_DATA:0] in_imag_1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic signed [Q_DATA:0] out_real_0,
  output logic signed [Q_DATA:0] out_imag_0,
  output logic signed [Q_DATA:0] out_real_1,
  output logic signed [Q_DATA:0] out_imag_1,
  output logic signed [Q_COEF:0] coeff_out_real,
  output logic signed [Q_COEF:0] coeff_out_imag,
  output logic                   err_sync
);

  localparam int AW = clog2(N);
  localparam int PW = AW - 1;
  localparam int DW = Q_DATA + 1;

  logic [1:0]      full, full_nxt;
  logic            wb, rb;
  logic [PW-1:0]   wp, rp;
  logic [2*DW-1:0] mem [2*N];
  logic            accept, wr_last, load, rd_last;
  logic [AW-1:0]   wa0, wa1;
  logic [2*DW-1:0] rd0, rd1;

  assign in_ready = !reset && !full[wb];
  assign accept   = in_valid && in_ready;
  assign wr_last  = (wp == PW'(N/2 - 1));
  assign wa0      = AW'(rotl(32'({wp, 1'b0}), ROT, AW));
  assign wa1      = AW'(rotl(32'({wp, 1'b1}), ROT, AW));

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wb, wa0}] <= {in_real_0, in_imag_0};
      mem[{wb, wa1}] <= {in_real_1, in_imag_1};
    end
  end

  // A read only targets a full bank, never the bank being written.
  assign rd0     = mem[{rb, rp, 1'b0}];
  assign rd1     = mem[{rb, rp, 1'b1}];
  assign load    = full[rb] && (!out_valid || out_ready);
  assign rd_last = (rp == PW'(N/2 - 1));

  always_comb begin
    full_nxt = full;
    if (accept && wr_last) full_nxt[wb] = 1'b1;
    if (load && rd_last)   full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= '0;
      wb       <= 1'b0;
      rb       <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      err_sync <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        wp <= wr_last ? '0 : wp + 1'b1;
        if (wr_last) wb <= ~wb;
        if (in_last != wr_last) err_sync <= 1'b1;
      end
      if (load) begin
        rp <= rd_last ? '0 : rp + 1'b1;
        if (rd_last) rb <= ~rb;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_real_0 <= '0;
      out_imag_0 <= '0;
      out_real_1 <= '0;
      out_imag_1 <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_last   <= rd_last;
      out_real_0 <= rd0[2*DW-1:DW];
      out_imag_0 <= rd0[DW-1:0];
      out_real_1 <= rd1[2*DW-1:DW];
      out_imag_1 <= rd1[DW-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  fft_twiddle_rom #(
    .N              (N),
    .Q_COEF         (Q_COEF),
    .COEF_REAL_FILE (COEF_REAL_FILE),
    .COEF_IMAG_FILE (COEF_IMAG_FILE)
  ) u_rom (
    .clk       (clk),
    .reset     (reset),
    .en        (load),
    .addr      ((AW-1)'(tw_idx(32'(rp), STAGE, N))),
    .coef_real (coeff_out_real),
    .coef_imag (coeff_out_imag)
  );

endmodule
